// File: rtl/ddmtd_stream_serializer.sv
// Wide-to-narrow AXI4-Stream serializer for the DDMTD sample stream.
// Each accepted beat is split into one output word per fully-strobed lane,
// emitted in ascending lane order with the lane index on M_AXIS_TUSER.
module ddmtd_stream_serializer #(
  parameter int unsigned NUM_DDMTD  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CH_W       = (NUM_DDMTD > 1) ? $clog2(NUM_DDMTD) : 1
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              reset,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [NUM_DDMTD*DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_DDMTD*DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]             M_AXIS_TDATA,
  output logic [CH_W-1:0]                   M_AXIS_TUSER,
  output logic                              M_AXIS_TLAST,
  output logic [31:0]                       beat_count,
  output logic [31:0]                       word_count,
  output logic                              strb_error,
  output logic                              busy
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StSer} state_e;

  state_e                            state_q, state_d;
  logic [NUM_DDMTD*DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [NUM_DDMTD-1:0]              mask_q, mask_d;
  logic                              last_q, last_d;
  logic [31:0]                       beat_q, beat_d;
  logic [31:0]                       word_q, word_d;
  logic                              strb_err_q, strb_err_d;

  logic [NUM_DDMTD-1:0] in_mask;
  logic                 in_partial;
  logic [StrbW-1:0]     lane_strb;
  logic [NUM_DDMTD-1:0] mask_clr;
  logic [CH_W-1:0]      cur_lane;
  logic                 found;
  logic                 one_left;
  logic                 s_hs;
  logic                 m_hs;

  // Qualify incoming lanes: full strobe = valid, partial strobe = error.
  always_comb begin
    in_mask    = '0;
    in_partial = 1'b0;
    lane_strb  = '0;
    for (int i = 0; i < NUM_DDMTD; i++) begin
      lane_strb  = S_AXIS_TSTRB[i*StrbW +: StrbW];
      in_mask[i] = &lane_strb;
      if ((|lane_strb) && !(&lane_strb)) in_partial = 1'b1;
    end
  end

  // Pick the lowest pending lane and the mask that remains once it is sent.
  always_comb begin
    mask_clr = mask_q;
    cur_lane = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_DDMTD; i++) begin
      if (mask_q[i] && !found) begin
        mask_clr[i] = 1'b0;
        cur_lane    = CH_W'(i);
        found       = 1'b1;
      end
    end
    one_left = found && (mask_clr == '0);
  end

  // Handshakes and stream outputs; input ready chains off downstream ready
  // on the final lane so full beats stream without bubbles.
  always_comb begin
    busy          = (state_q == StSer);
    M_AXIS_TVALID = busy;
    M_AXIS_TDATA  = busy ? buf_q[cur_lane*DATA_WIDTH +: DATA_WIDTH] : '0;
    M_AXIS_TUSER  = busy ? cur_lane : '0;
    M_AXIS_TLAST  = busy && last_q && one_left;
    S_AXIS_TREADY = !reset &&
                    ((state_q == StIdle) || (busy && M_AXIS_TREADY && one_left));
    s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    m_hs          = M_AXIS_TVALID && M_AXIS_TREADY;
    beat_count    = beat_q;
    word_count    = word_q;
    strb_error    = strb_err_q;
  end

  // Next-state: retire the current word, then (possibly same cycle) capture a new beat.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    last_d     = last_q;
    beat_d     = beat_q;
    word_d     = word_q;
    strb_err_d = strb_err_q;
    if (m_hs) begin
      mask_d = mask_clr;
      word_d = word_q + 32'd1;
      if (mask_clr == '0) state_d = StIdle;
    end
    if (s_hs) begin
      buf_d   = S_AXIS_TDATA;
      mask_d  = in_mask;
      last_d  = S_AXIS_TLAST;
      beat_d  = beat_q + 32'd1;
      state_d = (in_mask != '0) ? StSer : StIdle;
      if (in_partial) strb_err_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      word_q     <= '0;
      strb_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
      strb_err_q <= strb_err_d;
    end
  end

endmodule

// File: tb/tb_ddmtd_stream_serializer.sv
// Randomized bench for ddmtd_stream_serializer against a word-queue reference model.
module tb_ddmtd_stream_serializer;

  localparam int unsigned NL = 2;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tstrb = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [31:0]   m_tdata;
  logic [0:0]    m_tuser;
  logic          m_tlast;
  logic [31:0]   beat_count;
  logic [31:0]   word_count;
  logic          strb_error;
  logic          busy;

  ddmtd_stream_serializer #(
    .NUM_DDMTD (NL),
    .DATA_WIDTH(DW),
    .CH_W      (1)
  ) dut (
    .S_AXIS_ACLK  (clk),
    .reset        (reset),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TSTRB (s_tstrb),
    .S_AXIS_TLAST (s_tlast),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TUSER (m_tuser),
    .M_AXIS_TLAST (m_tlast),
    .beat_count   (beat_count),
    .word_count   (word_count),
    .strb_error   (strb_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int unsigned mdl_beats;
  int unsigned mdl_words;
  logic        mdl_serr;
  int          n_vec = 0;
  int          n_err = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Downstream ready, updated well clear of stimulus changes.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Reference model: every accepted beat expands into a list of expected words.
  task automatic model_accept(input logic [63:0] d, input logic [7:0] st, input logic tl);
    int last_lane = -1;
    word_t w;
    mdl_beats++;
    for (int i = 0; i < NL; i++) begin
      if (st[i*4 +: 4] == 4'hF) last_lane = i;
      else if (st[i*4 +: 4] != 4'h0) mdl_serr = 1'b1;
    end
    for (int i = 0; i < NL; i++) begin
      if (st[i*4 +: 4] == 4'hF) begin
        w.data = d[i*32 +: 32];
        w.user = i[0];
        w.last = tl && (i == last_lane);
        exp_q.push_back(w);
      end
    end
  endtask

  // Cycle monitor: valid iff words are pending; input ready iff at most the
  // final pending word remains and it is leaving this cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mdl_beats = 0;
      mdl_words = 0;
      mdl_serr  = 1'b0;
    end else begin
      check_eq("m_tvalid", {63'd0, m_tvalid}, {63'd0, exp_q.size() != 0});
      check_eq("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
      check_eq("s_tready", {63'd0, s_tready},
               {63'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && m_tready)});
      check_eq("beat_count", {32'd0, beat_count}, {32'd0, mdl_beats});
      check_eq("word_count", {32'd0, word_count}, {32'd0, mdl_words});
      check_eq("strb_error", {63'd0, strb_error}, {63'd0, mdl_serr});
      if (m_tvalid && exp_q.size() != 0) begin
        check_eq("m_tdata", {32'd0, m_tdata}, {32'd0, exp_q[0].data});
        check_eq("m_tuser", {63'd0, m_tuser}, {63'd0, exp_q[0].user});
        check_eq("m_tlast", {63'd0, m_tlast}, {63'd0, exp_q[0].last});
      end
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        mdl_words++;
      end
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tstrb, s_tlast);
    end
  end

  // Present one beat (called 1 time unit after a posedge); returns after its handshake edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] st, input logic tl);
    logic hs = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = tl;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
    end
    check_eq("s_handshake", {63'd0, hs}, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !m_tvalid;
    end
    check_eq("drain", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] st;

  initial begin
    // 1: reset held three cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check_eq("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check_eq("rst_beat_count", {32'd0, beat_count}, 64'd0);
    check_eq("rst_word_count", {32'd0, word_count}, 64'd0);
    check_eq("rst_strb_error", {63'd0, strb_error}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
    @(posedge clk);
    #1;

    // 2: single full beat, exact word sequence
    send_beat(64'hBBBB0001_AAAA0000, 8'hFF, 1'b1);
    @(negedge clk);
    check_eq("t2_w0_data", {32'd0, m_tdata}, 64'hAAAA0000);
    check_eq("t2_w0_user", {63'd0, m_tuser}, 64'd0);
    check_eq("t2_w0_last", {63'd0, m_tlast}, 64'd0);
    check_eq("t2_w0_s_tready", {63'd0, s_tready}, 64'd0);
    @(negedge clk);
    check_eq("t2_w1_data", {32'd0, m_tdata}, 64'hBBBB0001);
    check_eq("t2_w1_user", {63'd0, m_tuser}, 64'd1);
    check_eq("t2_w1_last", {63'd0, m_tlast}, 64'd1);
    check_eq("t2_w1_s_tready", {63'd0, s_tready}, 64'd1);
    @(negedge clk);
    check_eq("t2_beat_count", {32'd0, beat_count}, 64'd1);
    check_eq("t2_word_count", {32'd0, word_count}, 64'd2);
    @(posedge clk);
    #1;

    // 3: four full beats back to back
    for (int b = 0; b < 4; b++) send_beat({$urandom, $urandom}, 8'hFF, (b == 3));
    drain();
    check_eq("t3_word_count", {32'd0, word_count}, 64'd10);

    // 4: upper lane only, then an all-zero strobe beat
    send_beat(64'h12345678_9ABCDEF0, 8'hF0, 1'b1);
    drain();
    send_beat(64'h1111_2222_3333_4444, 8'h00, 1'b1);
    drain();
    check_eq("t4_beat_count", {32'd0, beat_count}, 64'd7);
    check_eq("t4_word_count", {32'd0, word_count}, 64'd11);

    // 5: partial strobe on lane 1, error stays sticky
    send_beat(64'hDEAD0001_CAFE0000, 8'h3F, 1'b1);
    drain();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    drain();
    check_eq("t5_strb_error", {63'd0, strb_error}, 64'd1);

    // Randomized traffic with random downstream stalls and idle gaps
    rdy_mode = 1;
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: st = 8'hFF;
        3:       st = 8'hF0;
        4:       st = 8'h0F;
        5:       st = 8'h00;
        default: st = 8'($urandom_range(0, 255));
      endcase
      send_beat({$urandom, $urandom}, st, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    drain();

    // 6: stalled output holds steady, then reset discards the pending lane
    rdy_mode = 2;
    idle_cycles(2);
    send_beat(64'h55550001_44440000, 8'hFF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_eq("t6_hold_valid", {63'd0, m_tvalid}, 64'd1);
      check_eq("t6_hold_data", {32'd0, m_tdata}, 64'h44440000);
      check_eq("t6_hold_user", {63'd0, m_tuser}, 64'd0);
      check_eq("t6_hold_s_tready", {63'd0, s_tready}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check_eq("t6_valid_after_rst", {63'd0, m_tvalid}, 64'd0);
    check_eq("t6_beats_after_rst", {32'd0, beat_count}, 64'd0);
    check_eq("t6_words_after_rst", {32'd0, word_count}, 64'd0);
    check_eq("t6_serr_after_rst", {63'd0, strb_error}, 64'd0);
    idle_cycles(5);
    send_beat(64'h0BAD0F00_600DF00D, 8'hFF, 1'b1);
    drain();
    check_eq("t6_words_recover", {32'd0, word_count}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
